serial_adder: RTL
=================

# serial_adder

Bit-serial two-operand adder for the score and position arithmetic path. It sits directly downstream of the `fulladd` cell: one `fulladd` instance is driven for WIDTH consecutive cycles, LSB first, and its carry-out is fed back through a carry flip-flop. Operands load in parallel on a start request. The result is presented in parallel with a one-cycle done pulse, trading latency for a single adder cell.

## Interface
- WIDTH, default 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepted start edge
- b  input  WIDTH  operand B, captured on the accepted start edge
- sub  input  1  only with SERIAL_ADDER_SUB_EN; 1 = A−B, captured with operands
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result, held until the next accepted start
- cout  output  1  final carry-out of the MSB
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN** on start=1.
  - Load a_sr←a, b_sr←b, carry←0, bit count←0, sum_sr←0.
- **RUN, each cycle:**
  - Drive `fulladd` with a_sr[0], b_sr[0], carry.
  - Shift a_sr and b_sr right by 1.
  - sum_sr ← {s, sum_sr[WIDTH-1:1]}.
  - carry←cout.
  - Keep the previous carry in prev_carry.
  - Increment count.
- **RUN → DONE** when count = WIDTH−1, after that bit has been processed.
- **DONE:**
  - done=1 for one cycle.
  - sum, cout and overflow are registered from sum_sr, carry and carry^prev_carry.
  - Unconditional transition to IDLE.
- **Holding and ignored starts:**
  - sum, cout and overflow hold their values until the next accepted start. They are cleared to 0 on that start edge.
  - start during RUN or DONE is ignored; it is not queued.
  - start in the IDLE cycle directly after DONE is accepted.
- **Arithmetic:** mod 2^WIDTH.
  - cout = bit WIDTH of the unsigned sum.
  - overflow = signed overflow.
- **Reset**, at any time including mid-RUN: state=IDLE. busy, done, sum, cout, overflow, all shift registers, carry and count are 0. The operation in flight is discarded.

## Timing
- Accepted start at clock edge E0: busy=1 from E0. RUN occupies edges E1..EWIDTH. done=1 after edge EWIDTH+1, for exactly one cycle. busy=0 after EWIDTH+2.
- Start-to-done latency is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- Operand inputs are don't-care except on the accepting edge.

## Configuration
- **SERIAL_ADDER_SUB_EN defined:**
  - sub port exists, captured with operands.
  - sub=1: B bits are inverted into `fulladd` and carry initialises to 1, giving A−B.
  - cout=1 means no borrow. overflow is signed-subtract overflow.
- **Undefined:** sub port absent; addition only, carry initialises to 0.

## Structure
- A shared package (`serial_adder_pkg`) holds:
  - the state enum (IDLE, RUN, DONE);
  - the default-WIDTH constant;
  - the count width function ($clog2(WIDTH)).
- Single sub-module: `fulladd`, instantiated once.
- FSM, shift registers and result registers live in `serial_adder`.

## Test plan
- **Add:** WIDTH=8, a=3, b=5, start pulse → done exactly 9 cycles after the start edge; sum=8, cout=0, overflow=0; busy low the following cycle.
- **Carry out:** a=255, b=1 → sum=0, cout=1, overflow=0.
- **Signed overflow:** a=127, b=1 → sum=128, cout=0, overflow=1. Then a=128, b=128 → sum=0, cout=1, overflow=1.
- **Start while busy:** a=10, b=20 started; start held high with a=1, b=1 for 4 cycles mid-RUN → single done, sum=30. The next start in IDLE is accepted.
- **Reset mid-op:** start a=200, b=100, assert reset at the 3rd RUN cycle → all outputs 0, state IDLE, no done pulse. A following start with a=1, b=2 → sum=3.
- **SUB (SERIAL_ADDER_SUB_EN):** a=5, b=3, sub=1 → sum=2, cout=1. a=3, b=5, sub=1 → sum=254, cout=0, overflow=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtraction support is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; the width is always at least 2, so this is never zero.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fulladd.sv
// Single-bit full adder cell; the serial adder reuses one instance every cycle.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two-operand adder: one fulladd cell stepped LSB first, WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A-B via inverted B, carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             prev_carry;
  logic [CW-1:0]    count;
  logic             sub_r;
  logic             sub_in;
  logic             accept;
  logic             last_bit;
  logic             fa_b;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign accept   = (state == IDLE) && start;
  assign last_bit = (count == CW'(WIDTH - 1));

  // Subtraction feeds the one's complement of B; the +1 comes from the carry seed.
  assign fa_b = b_sr[0] ^ sub_r;

  fulladd u_fulladd (
    .a    (a_sr[0]),
    .b    (fa_b),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand load and serial datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      sum_sr     <= '0;
      carry      <= 1'b0;
      prev_carry <= 1'b0;
      count      <= '0;
      sub_r      <= 1'b0;
    end else if (accept) begin
      a_sr       <= a;
      b_sr       <= b;
      sum_sr     <= '0;
      carry      <= sub_in;
      prev_carry <= 1'b0;
      count      <= '0;
      sub_r      <= sub_in;
    end else if (state == RUN) begin
      a_sr       <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr     <= {fa_s, sum_sr[WIDTH-1:1]};
      prev_carry <= carry;
      carry      <= fa_co;
      count      <= count + 1'b1;
    end
  end

  // Result registers: cleared on accept, loaded in DONE, otherwise held
  always_ff @(posedge clk) begin
    if (reset) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept) begin
        sum      <= '0;
        cout     <= 1'b0;
        overflow <= 1'b0;
      end else if (state == DONE) begin
        sum      <= sum_sr;
        cout     <= carry;
        overflow <= carry ^ prev_carry;
      end
    end
  end

  // busy stays high through the done cycle so it drops one edge after done rises
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
    end else if (accept) begin
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

endmodule
